// File: rtl/cursor_ctrl.sv
// cursor_ctrl
// Turns decoded PS/2 key events into a cursor position on a COLS x ROWS grid.
// It supports 8-direction movement, clamp or wrap edges, optional E0 arrow keys
// and typematic auto-repeat. Select and cancel are single-cycle pulses.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   key_event     [10] make/held, [8] E0-extended, [7:0] scan code ([9] unused)
//   cursor_x/y    current cursor column / row
//   select_pulse  one cycle on a new Space / Enter press
//   cancel_pulse  one cycle on a new Esc press
//   move_pulse    one cycle whenever the cursor actually changes
//   bump_pulse    one cycle when a move is fully blocked by clamping
//
// Latency: the key word is registered into ev_q, and the cursor and pulses
// update on the following edge. All outputs are registered.
module cursor_ctrl #(
  parameter int COLS          = 8,
  parameter int ROWS          = 8,
  parameter int COORD_W       = 4,
  parameter int INIT_X        = 0,
  parameter int INIT_Y        = 0,
  parameter int WRAP          = 0,
  parameter int ARROWS_EN     = 1,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        key_event,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic               select_pulse,
  output logic               cancel_pulse,
  output logic               move_pulse,
  output logic               bump_pulse
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W:0] MAX_X = CW1'(COLS - 1);
  localparam logic [COORD_W:0] MAX_Y = CW1'(ROWS - 1);
  localparam logic [31:0] DELAY_LOAD  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PERIOD_LOAD = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

  state_t      state;
  logic [10:0] ev_q;
  logic [10:0] ev_p;
  logic [8:0]  lat_code;
  logic [31:0] cnt;

  // Bit 9 of the key word carries no meaning here.
  logic unused_bits;
  assign unused_bits = ^{ev_q[9], ev_p[9]};

  // Classification of the registered key word.
  logic mv_valid, dx_neg, dx_pos, dy_neg, dy_pos, is_sel, is_can;

  always_comb begin
    mv_valid = 1'b0;
    dx_neg   = 1'b0;
    dx_pos   = 1'b0;
    dy_neg   = 1'b0;
    dy_pos   = 1'b0;
    is_sel   = 1'b0;
    is_can   = 1'b0;
    if (ev_q[10]) begin
      if (!ev_q[8]) begin
        case (ev_q[7:0])
          8'h1D: begin mv_valid = 1'b1; dy_neg = 1'b1; end
          8'h22: begin mv_valid = 1'b1; dy_pos = 1'b1; end
          8'h1C: begin mv_valid = 1'b1; dx_neg = 1'b1; end
          8'h23: begin mv_valid = 1'b1; dx_pos = 1'b1; end
          8'h15: begin mv_valid = 1'b1; dx_neg = 1'b1; dy_neg = 1'b1; end
          8'h24: begin mv_valid = 1'b1; dx_pos = 1'b1; dy_neg = 1'b1; end
          8'h1A: begin mv_valid = 1'b1; dx_neg = 1'b1; dy_pos = 1'b1; end
          8'h21: begin mv_valid = 1'b1; dx_pos = 1'b1; dy_pos = 1'b1; end
          8'h29, 8'h5A: is_sel = 1'b1;
          8'h76:        is_can = 1'b1;
          default: ;
        endcase
      end else if (ARROWS_EN != 0) begin
        case (ev_q[7:0])
          8'h75: begin mv_valid = 1'b1; dy_neg = 1'b1; end
          8'h72: begin mv_valid = 1'b1; dy_pos = 1'b1; end
          8'h6B: begin mv_valid = 1'b1; dx_neg = 1'b1; end
          8'h74: begin mv_valid = 1'b1; dx_pos = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // A held key with an unchanged code is never a new press.
  logic new_press;
  assign new_press = ev_q[10] && (!ev_p[10] || (ev_p[8:0] != ev_q[8:0]));

  // Next position; one extra bit of headroom so +1 at the top cannot overflow.
  logic [COORD_W:0] x_ext, y_ext, nx, ny;
  logic             changed, has_dir;

  always_comb begin
    x_ext = {1'b0, cursor_x};
    y_ext = {1'b0, cursor_y};
    nx    = x_ext;
    ny    = y_ext;
    if (dx_neg)      nx = (x_ext == '0)    ? ((WRAP != 0) ? MAX_X : x_ext) : x_ext - CW1'(1);
    else if (dx_pos) nx = (x_ext == MAX_X) ? ((WRAP != 0) ? '0 : x_ext)    : x_ext + CW1'(1);
    if (dy_neg)      ny = (y_ext == '0)    ? ((WRAP != 0) ? MAX_Y : y_ext) : y_ext - CW1'(1);
    else if (dy_pos) ny = (y_ext == MAX_Y) ? ((WRAP != 0) ? '0 : y_ext)    : y_ext + CW1'(1);
    changed = (nx != x_ext) || (ny != y_ext);
    has_dir = dx_neg || dx_pos || dy_neg || dy_pos;
  end

  // Step decisions. A new press always wins over the repeat timer; a timer
  // step needs the latched key still held with the same code.
  logic press_move, press_other, key_same, rep_step, step_now;
  assign press_move  = new_press && mv_valid;
  assign press_other = new_press && (is_sel || is_can);
  assign key_same    = ev_q[10] && (ev_q[8:0] == lat_code);
  assign rep_step    = (state != ST_IDLE) && !press_move && !press_other &&
                       key_same && (cnt == '0);
  assign step_now    = press_move || rep_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ev_q         <= '0;
      ev_p         <= '0;
      lat_code     <= '0;
      cnt          <= '0;
      cursor_x     <= COORD_W'(INIT_X);
      cursor_y     <= COORD_W'(INIT_Y);
      select_pulse <= 1'b0;
      cancel_pulse <= 1'b0;
      move_pulse   <= 1'b0;
      bump_pulse   <= 1'b0;
    end else begin
      ev_q         <= key_event;
      ev_p         <= ev_q;
      select_pulse <= 1'b0;
      cancel_pulse <= 1'b0;
      move_pulse   <= 1'b0;
      bump_pulse   <= 1'b0;

      if (step_now) begin
        cursor_x   <= nx[COORD_W-1:0];
        cursor_y   <= ny[COORD_W-1:0];
        move_pulse <= changed;
        bump_pulse <= has_dir && !changed;
      end

      if (press_move) begin
        cnt      <= DELAY_LOAD;
        lat_code <= ev_q[8:0];
        state    <= (REPEAT_EN != 0) ? ST_DELAY : ST_IDLE;
      end else if (press_other) begin
        select_pulse <= is_sel;
        cancel_pulse <= is_can;
        state        <= ST_IDLE;
      end else if (state != ST_IDLE) begin
        if (!key_same) begin
          state <= ST_IDLE;
        end else if (cnt == '0) begin
          cnt   <= PERIOD_LOAD;
          state <= ST_REPEAT;
        end else begin
          cnt <= cnt - 32'd1;
        end
      end
    end
  end

endmodule
